// File: rtl/trace_decoder.sv
// Trace-port receiver: classifies 36-bit trace words by tag, keeps branch/IRQ
// event counters and the last branch target, and queues classified words for a debug consumer.
module trace_decoder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             trace_valid,
  input  logic [35:0]      trace_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_kind,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] irq_cnt,
  output logic [31:0]      last_target,
  output logic             overflow,
  input  logic             clear
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    KindData   = 2'd0,
    KindBranch = 2'd1,
    KindAddr   = 2'd2,
    KindIrq    = 2'd3
  } kind_e;

  logic [3:0]  tag;
  logic [31:0] payload;
  kind_e       kind;

  assign tag     = trace_data[35:32];
  assign payload = trace_data[31:0];

  // Class priority IRQ > ADDR > BRANCH > data; bit2 carries no meaning.
  always_comb begin
    kind = KindData;
    if (tag[3]) begin
      kind = KindIrq;
    end else if (tag[1]) begin
      kind = KindAddr;
    end else if (tag[0]) begin
      kind = KindBranch;
    end
  end

  // FIFO state
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [33:0]   mem_q [DEPTH];
  logic [33:0]   head;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the word.
  assign push      = trace_valid && (!full || pop);
  assign drop      = trace_valid && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {kind, payload};
    end
  end

  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign out_kind = out_valid ? head[33:32] : 2'b00;
  assign out_data = out_valid ? head[31:0]  : 32'h0;

  // Event counters and sticky overflow
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] irq_cnt_q, irq_cnt_d;
  logic [31:0]      last_target_q, last_target_d;
  logic             overflow_q, overflow_d;
  logic             branch_hit;
  logic             irq_hit;

  assign branch_hit = trace_valid && tag[0];
  assign irq_hit    = trace_valid && tag[3];

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    irq_cnt_d     = irq_cnt_q;
    last_target_d = last_target_q;
    overflow_d    = overflow_q;

    if (branch_hit) begin
      last_target_d = payload;
      if (branch_cnt_q != {CNT_W{1'b1}}) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
    end
    if (irq_hit && (irq_cnt_q != {CNT_W{1'b1}})) begin
      irq_cnt_d = irq_cnt_q + CNT_W'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
    end

    // Clear dominates same-cycle events but leaves last_target alone.
    if (clear) begin
      branch_cnt_d = '0;
      irq_cnt_d    = '0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      branch_cnt_q  <= '0;
      irq_cnt_q     <= '0;
      last_target_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      irq_cnt_q     <= irq_cnt_d;
      last_target_q <= last_target_d;
      overflow_q    <= overflow_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign irq_cnt     = irq_cnt_q;
  assign last_target = last_target_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_trace_decoder.sv
// Scoreboard bench for trace_decoder: the negedge monitor tracks every issued word in an
// expected-FIFO queue and checks the DUT head; directed checks cover counters and flags.
module tb_trace_decoder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             resetn;
  logic             trace_valid;
  logic [35:0]      trace_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_kind;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] irq_cnt;
  logic [31:0]      last_target;
  logic             overflow;
  logic             clear;

  int passed = 0;
  int total  = 0;

  logic [33:0] exp_q[$];

  trace_decoder #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .trace_valid(trace_valid),
    .trace_data (trace_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kind   (out_kind),
    .out_data   (out_data),
    .branch_cnt (branch_cnt),
    .irq_cnt    (irq_cnt),
    .last_target(last_target),
    .overflow   (overflow),
    .clear      (clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] kind_of(input logic [3:0] tag);
    if (tag[3]) return 2'd3;
    if (tag[1]) return 2'd2;
    if (tag[0]) return 2'd1;
    return 2'd0;
  endfunction

  // Monitor/scoreboard: compare head against the expected queue, then advance the queue
  // with whatever the upcoming rising edge will pop and push.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
    end else begin
      logic exp_valid;
      logic do_pop;
      logic do_push;
      exp_valid = (exp_q.size() > 0);
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
      if (exp_valid) begin
        check("out_kind", {62'd0, out_kind}, {62'd0, exp_q[0][33:32]});
        check("out_data", {32'd0, out_data}, {32'd0, exp_q[0][31:0]});
      end else begin
        check("empty_kind", {62'd0, out_kind}, 64'd0);
        check("empty_data", {32'd0, out_data}, 64'd0);
      end
      do_pop  = exp_valid && out_ready;
      do_push = trace_valid && ((exp_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({kind_of(trace_data[35:32]), trace_data[31:0]});
    end
  end

  task automatic send(input logic [3:0] tag, input logic [31:0] pl);
    trace_valid = 1'b1;
    trace_data  = {tag, pl};
    @(posedge clk);
    #1;
    trace_valid = 1'b0;
    trace_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn      = 1'b0;
    trace_valid = 1'b0;
    trace_data  = '0;
    out_ready   = 1'b0;
    clear       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_kind", {62'd0, out_kind}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_branch_cnt", {60'd0, branch_cnt}, 64'd0);
    check("rst_irq_cnt", {60'd0, irq_cnt}, 64'd0);
    check("rst_last_target", {32'd0, last_target}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    resetn    = 1'b1;
    out_ready = 1'b1;
    idle(1);

    // Basic classification and counters
    send(4'b0001, 32'h1000);
    send(4'b0000, 32'h5);
    send(4'b1000, 32'h0);
    idle(1);
    check("t1_branch_cnt", {60'd0, branch_cnt}, 64'd1);
    check("t1_irq_cnt", {60'd0, irq_cnt}, 64'd1);
    check("t1_last_target", {32'd0, last_target}, 64'h1000);
    send(4'b1001, 32'h2000);
    check("t2_branch_cnt", {60'd0, branch_cnt}, 64'd2);
    check("t2_irq_cnt", {60'd0, irq_cnt}, 64'd2);
    check("t2_last_target", {32'd0, last_target}, 64'h2000);
    send(4'b0011, 32'h3000);
    send(4'b0100, 32'h44);
    idle(4);
    check("t3_branch_cnt", {60'd0, branch_cnt}, 64'd3);
    check("t3_last_target", {32'd0, last_target}, 64'h3000);
    check("t3_irq_cnt", {60'd0, irq_cnt}, 64'd2);

    // Overflow: consumer stalled, DEPTH+2 branch words
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      send(4'b0001, 32'(i));
      if (i == DEPTH - 1) check("ovf_before_drop", {63'd0, overflow}, 64'd0);
      if (i == DEPTH) check("ovf_after_drop", {63'd0, overflow}, 64'd1);
    end
    check("ovf_branch_cnt", {60'd0, branch_cnt}, 64'd13);
    check("ovf_last_target", {32'd0, last_target}, 64'd9);
    out_ready = 1'b1;
    idle(DEPTH + 2);
    check("ovf_drained", {63'd0, out_valid}, 64'd0);

    // Clear pulse without traffic
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    check("clr_branch_cnt", {60'd0, branch_cnt}, 64'd0);
    check("clr_irq_cnt", {60'd0, irq_cnt}, 64'd0);
    check("clr_overflow", {63'd0, overflow}, 64'd0);
    check("clr_last_target", {32'd0, last_target}, 64'd9);

    // Fill, then stream with push+pop on a full FIFO
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(4'b0000, 32'h100 + 32'(i));
    check("full_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(4'b0110, 32'h200 + 32'(i));
    check("stream_overflow", {63'd0, overflow}, 64'd0);
    idle(DEPTH + 2);

    // Saturation, then clear racing a branch word
    for (int i = 0; i < 20; i++) send(4'b0001, 32'h300 + 32'(i));
    check("sat_branch_cnt", {60'd0, branch_cnt}, 64'd15);
    check("sat_last_target", {32'd0, last_target}, 64'h313);
    clear = 1'b1;
    send(4'b0001, 32'hABCD);
    clear = 1'b0;
    check("clrwin_branch_cnt", {60'd0, branch_cnt}, 64'd0);
    check("clrwin_overflow", {63'd0, overflow}, 64'd0);
    check("clrwin_last_target", {32'd0, last_target}, 64'hABCD);
    idle(3);

    // Asynchronous reset with five entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'b1001, 32'h400 + 32'(i));
    check("pre_rst_branch_cnt", {60'd0, branch_cnt}, 64'd5);
    check("pre_rst_irq_cnt", {60'd0, irq_cnt}, 64'd5);
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_branch_cnt", {60'd0, branch_cnt}, 64'd0);
    check("arst_irq_cnt", {60'd0, irq_cnt}, 64'd0);
    check("arst_last_target", {32'd0, last_target}, 64'd0);
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    send(4'b1000, 32'h55);
    check("post_rst_irq_cnt", {60'd0, irq_cnt}, 64'd1);
    idle(4);
    check("post_rst_drained", {63'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/trace_decoder.md
# trace_decoder

Receiver for the 36-bit core execution-trace stream, where each word is a 4-bit tag in bits [35:32] and a 32-bit payload in bits [31:0]. It sits beside the CPU core on the trace port. It classifies each word by tag, keeps branch and IRQ event counters, and records the last branch target. It buffers classified words in a small FIFO so a slower debug consumer can drain them with ready/valid.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥ 2.
- CNT_W, 16: width of the event counters.

Ports:
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- trace_valid  in  1  trace word present this cycle; the producer has no backpressure.
- trace_data  in  36  tag [35:32] plus payload [31:0].
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_kind  out  2  head class: 0 data, 1 branch, 2 addr, 3 irq.
- out_data  out  32  head payload.
- branch_cnt  out  CNT_W  count of branch-tagged words accepted on the port.
- irq_cnt  out  CNT_W  count of irq-tagged words accepted on the port.
- last_target  out  32  payload of the most recent branch-tagged word.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
- clear  in  1  synchronous clear of the counters and overflow.

## Operation
- Tag bits are decoded as follows:
  - bit3 = IRQ (4'b1000).
  - bit1 = ADDR (4'b0010).
  - bit0 = BRANCH (4'b0001).
  - bit2 is ignored.
- Tag bits can be set together. out_kind uses priority IRQ > ADDR > BRANCH > data; tag 4'b0000 (or only bit2 set) gives kind 0.
- Counters react to tag bits independently of kind:
  - bit0 set → branch_cnt +1 and last_target ← payload.
  - bit3 set → irq_cnt +1.
  - Both set in one word → both update.
- Counters and last_target update on every trace_valid, even when the FIFO drops the word.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- FIFO entry is {kind, payload}, 34 bits. It is show-ahead: out_kind and out_data always present the head.
- out_valid = not empty. A pop happens when out_valid && out_ready.
- Push: trace_valid && (not full || pop this cycle).
  - When full, a simultaneous pop makes room, so the word is accepted and occupancy stays DEPTH.
- Drop: trace_valid && full && no pop. The word is discarded, overflow ← 1, and FIFO contents are unchanged.
- Push and pop on a non-full, non-empty FIFO leave occupancy unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full and empty come from comparing the pointer MSBs.
- clear (synchronous):
  - branch_cnt, irq_cnt and overflow ← 0, and clear wins over same-cycle increments and drops.
  - last_target and the FIFO are not affected.
- Reset values:
  - FIFO empty, so out_valid = 0.
  - branch_cnt = 0, irq_cnt = 0, last_target = 0, overflow = 0.
  - out_kind and out_data read as 0 while empty.
- Reset mid-operation flushes the FIFO immediately (asynchronously) and drops any in-flight word.

## Timing
- Latency: a word pushed at edge N into an empty FIFO gives out_valid = 1 with that word after edge N; it is visible in cycle N+1.
- Counters and last_target reflect a word from edge N after edge N.
- overflow rises after the edge at which the drop occurs.
- Throughput: one push and one pop per cycle, sustained.
- The consumer may hold out_ready high continuously. The head is stable while out_valid && !out_ready.
- No combinational path from trace_* to out_*. out_valid depends only on registered pointers.

## Test plan
- Reset, then three words: tags 0001 (payload 0x1000), 0000 (0x5), 1000 (0x0).
  - Required: out_kind sequence 1,0,3 and payloads in order.
  - Required: branch_cnt = 1, irq_cnt = 1, last_target = 0x1000.
- Word with tag 1001, payload 0x2000 → kind 3, branch_cnt +1, irq_cnt +1, last_target = 0x2000.
- out_ready = 0, push DEPTH+2 words with payloads 0..9.
  - Required: overflow = 1 after word 8 (payload 8).
  - Required: drain yields payloads 0..7 only; branch_cnt counts all 10 if they are branch-tagged.
- FIFO full with out_ready = 1 and trace_valid every cycle for 20 cycles.
  - Required: no drop, overflow stays 0, output order matches input.
- CNT_W = 4: 20 branch words → branch_cnt = 15 (saturated). Then clear together with a branch word → branch_cnt = 0, overflow = 0, last_target = that word's payload.
- Assert resetn low while the FIFO holds 5 entries → out_valid = 0 and counters = 0 in the same cycle. The first word after reset appears at the head.
